// File: rtl/sram_rw_initiator_if.sv
// sram_rw_initiator_if: request/response handshake bundle between a cache controller and the SRAM initiator
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata/req_wmask carry requests; resp_valid/resp_ready/resp_rdata return read data
interface sram_rw_initiator_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_rw_initiator.sv
// sram_rw_initiator: zero-fills a masked single-port SRAM after reset, then maps a request stream onto RW0 cycles
// Ports: clock (also RW0_clk), reset_n (async, active-low); bus = request/response stream (slave side);
//        init_done high once the zero-fill completes; sram_addr/en/wmode/wmask/wdata drive RW0_*, sram_rdata from RW0_rdata
module sram_rw_initiator #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_rw_initiator_if.slave bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] init_ctr;
  logic              rd_pend, fire, push, pop, wr_ptr, rd_ptr;
  logic [1:0]        cnt, occ;
  logic [DATA_W-1:0] fifo_q [2];
  // occ counts every read accepted but not yet consumed, so the FIFO can never be overrun
  assign occ            = cnt + {1'b0, rd_pend};
  assign pop            = bus.resp_valid && bus.resp_ready;
  assign push           = rd_pend;
  assign bus.req_ready  = state == RUN && (occ < 2'd2 || pop);
  assign fire           = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = cnt != 2'd0;
  assign bus.resp_rdata = fifo_q[rd_ptr];
  assign init_done      = state == RUN;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= INIT;
    else state <= state_nx;
  always_comb begin
    state_nx   = state == INIT && init_ctr == ADDR_W'(DEPTH - 1) ? RUN : state;
    sram_en    = state == INIT || fire;
    sram_wmode = state == INIT || bus.req_write;
    sram_addr  = state == INIT ? init_ctr : bus.req_addr;
    sram_wmask = state == INIT ? '1 : bus.req_wmask;
    sram_wdata = state == INIT ? '0 : bus.req_wdata;
  end
  // Read data is valid exactly one cycle after the enable, so it is captured unconditionally then
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      init_ctr  <= '0;
      rd_pend   <= 1'b0;
      cnt       <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      assert (!(push && cnt == 2'd2));
      if (state == INIT) init_ctr <= init_ctr + 1'b1;
      rd_pend <= fire && !bus.req_write;
      if (push) fifo_q[wr_ptr] <= sram_rdata;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      cnt    <= cnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_sram_rw_initiator.sv
// tb_sram_rw_initiator: randomized and directed bench for sram_rw_initiator against a queue/array reference model
module tb_sram_rw_initiator;
  localparam int ADDR_W = 8, DEPTH = 256, DATA_W = 256, MASK_W = 32, LANE = DATA_W / MASK_W;
  typedef struct {logic [DATA_W-1:0] data; int cyc;} rsp_t;
  logic              clock = 1'b0, reset_n = 1'b1;
  logic              init_done, sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] exp_mem [2**ADDR_W];
  rsp_t              exp_q [$];
  int                cyc, since, checks, fails;
  sram_rw_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();
  sram_rw_initiator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock)
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) mem[sram_addr][l*LANE +: LANE] <= sram_wdata[l*LANE +: LANE];
      end else sram_rdata <= mem[sram_addr];
    end
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle(output logic f);
    logic vexp, rexp, pop;
    #1;
    f   = bus.req_valid && bus.req_ready;
    pop = bus.resp_valid && bus.resp_ready;
    if (since < DEPTH)
      check("init", 320'({sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata, init_done, bus.req_ready, bus.resp_valid}),
                    320'({1'b1, 1'b1, {MASK_W{1'b1}}, ADDR_W'(since), {DATA_W{1'b0}}, 3'b000}));
    else begin
      vexp = exp_q.size() != 0 && exp_q[0].cyc + 2 <= cyc;
      rexp = exp_q.size() < 2 || (vexp && bus.resp_ready);
      check("hs", 320'({init_done, bus.req_ready, bus.resp_valid, sram_en}),
                  320'({1'b1, rexp, vexp, bus.req_valid && rexp}));
      if (sram_en)
        check("sram_bus", 320'({sram_wmode, sram_addr, sram_wmask, sram_wdata}),
                          320'({bus.req_write, bus.req_addr, bus.req_wmask, bus.req_wdata}));
      if (pop && exp_q.size() != 0) check("rdata", 320'(bus.resp_rdata), 320'(exp_q[0].data));
    end
    @(posedge clock);
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (f && !bus.req_write) exp_q.push_back('{exp_mem[bus.req_addr], cyc});
    if (f && bus.req_write)
      for (int l = 0; l < MASK_W; l++)
        if (bus.req_wmask[l]) exp_mem[bus.req_addr][l*LANE +: LANE] = bus.req_wdata[l*LANE +: LANE];
    cyc++;
    since++;
    @(negedge clock);
  endtask
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [MASK_W-1:0] m, output int n);
    logic f;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    n = 0;
    do begin
      cycle(f);
      n++;
    end while (!f && n < 50);
    if (!f) check("send_timeout", 320'(f), 320'(1));
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    logic f;
    int n = 0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      cycle(f);
      n++;
    end
    check("drain", 320'(exp_q.size()), 320'(0));
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst", 320'({init_done, bus.req_ready, bus.resp_valid, bus.resp_rdata}), 320'(0));
    exp_q.delete();
    for (int i = 0; i < 2**ADDR_W; i++) exp_mem[i] = '0;
    since = 0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, tot;
    logic f;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b0;
    @(negedge clock);
    do_reset();
    repeat (DEPTH) cycle(f);
    bus.resp_ready = 1'b1;
    send(1'b0, 8'h7F, '0, '0, n);
    drain();
    send(1'b1, 8'h10, {32{8'hA5}}, 32'h0000000F, n);
    send(1'b0, 8'h10, '0, '0, n);
    drain();
    bus.resp_ready = 1'b0;
    send(1'b0, 8'h01, '0, '0, n);
    send(1'b0, 8'h02, '0, '0, n);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h03;
    tot = 0;
    repeat (4) begin
      cycle(f);
      tot += int'(f);
    end
    check("t3_stall", 320'(tot), 320'(0));
    bus.resp_ready = 1'b1;
    send(1'b0, 8'h03, '0, '0, n);
    send(1'b0, 8'h04, '0, '0, n);
    drain();
    send(1'b0, 8'h20, '0, '0, n);
    send(1'b1, 8'h20, '1, '1, n);
    send(1'b0, 8'h20, '0, '0, n);
    drain();
    tot = 0;
    for (int a = 0; a < 16; a++) begin
      send(1'b0, ADDR_W'(a), '0, '0, n);
      tot += n;
    end
    check("t5_rate", 320'(tot), 320'(16));
    drain();
    repeat (400) begin
      bus.req_valid  = 1'($urandom % 2);
      bus.req_write  = 1'($urandom % 2);
      bus.req_addr   = 8'h40 + 8'($urandom % 8);
      bus.req_wdata  = {8{$urandom}};
      bus.req_wmask  = $urandom;
      bus.resp_ready = ($urandom % 4) != 0;
      cycle(f);
    end
    drain();
    do_reset();
    repeat (100) cycle(f);
    do_reset();
    repeat (DEPTH + 2) cycle(f);
    bus.resp_ready = 1'b0;
    send(1'b0, 8'h10, '0, '0, n);
    send(1'b0, 8'h11, '0, '0, n);
    check("pre_rst_valid", 320'(bus.resp_valid), 320'(1));
    #3;
    do_reset();
    repeat (DEPTH) cycle(f);
    bus.resp_ready = 1'b1;
    repeat (10) cycle(f);
    send(1'b0, 8'h10, '0, '0, n);
    send(1'b0, 8'h20, '0, '0, n);
    drain();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
